// File: rtl/rect_addr_gen_if.sv
// rect_addr_gen_if -- AXI4-Stream style handshake bundle used for both the
// remap-map input stream and the address output stream of rect_addr_gen.
//
// Parameter:
//   W        data width of tdata
// Signals:
//   tvalid   producer has a word on tdata/tlast
//   tready   consumer can accept a word this cycle
//   tlast    marks the final word of a frame
//   tdata    payload
// Modports:
//   master   drives tvalid/tlast/tdata, samples tready
//   slave    samples tvalid/tlast/tdata, drives tready
interface rect_addr_gen_if #(
  parameter int W = 32
) ();
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/rect_addr_gen.sv
// rect_addr_gen -- turns a stream of signed (x,y) remap coordinates into
// source-pixel byte addresses (2 bytes per pixel) for a fetch stage.
//
// Ports:
//   aclk, areset        clock; synchronous active-high reset
//   start               frame start request, honoured only in IDLE
//   cfg_base            byte address of source pixel (0,0)
//   cfg_width/height    source image size in pixels (12 bits each)
//   s_axis (slave)      map words: [15:0] signed x, [31:16] signed y
//   m_axis (master)     byte addresses, tlast on the final pixel of the frame
//   busy                high in RUN and DONE
//   done                one-cycle pulse while in DONE
//   frame_err           sticky: input tlast disagreed with the raster position
//   oob_count           saturating count of out-of-range coordinates
//   state_out           IDLE=0, RUN=1, DONE=2
//
// Build option:
//   RECT_ADDR_CLAMP_EN  defined: out-of-range coordinates are clamped to the
//                       image edge; undefined: they emit FILL_ADDR.
module rect_addr_gen #(
  parameter logic [31:0] FILL_ADDR          = 32'h40000000,
  parameter int          C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic [31:0]         cfg_base,
  input  logic [11:0]         cfg_width,
  input  logic [11:0]         cfg_height,
  rect_addr_gen_if.slave      s_axis,
  rect_addr_gen_if.master     m_axis,
  output logic                busy,
  output logic                done,
  output logic                frame_err,
  output logic [15:0]         oob_count,
  output logic [1:0]          state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [31:0]                     base_q;
  logic [11:0]                     width_q, height_q;
  logic [11:0]                     col_q, row_q;
  logic                            vld_p0, tlast_p0;
  logic [C_AXIS_TDATA_WIDTH-1:0]   tdata_p0;
  logic                            in_hs, out_hs, last_word, in_range;
  logic signed [15:0]              src_x, src_y;
  logic [31:0]                     addr_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Clamp a signed coordinate into [0, lim-1]; lim is never 0 while running.
  function automatic logic [11:0] clamp_coord(input logic signed [15:0] c,
                                              input logic [11:0] lim);
    logic [11:0] r;
    if (c[15])                             r = '0;
    else if ($unsigned(c) >= {4'd0, lim})  r = lim - 12'd1;
    else                                   r = c[11:0];
    return r;
  endfunction

  // base + ((y*w + x) << 1): 24-bit product, sum wraps at 32 bits.
  function automatic logic [31:0] pix_addr(input logic [31:0] base,
                                           input logic [11:0] w,
                                           input logic [11:0] x,
                                           input logic [11:0] y);
    logic [23:0] prod;
    logic [24:0] lin;
    prod = {12'd0, y} * {12'd0, w};
    lin  = {1'b0, prod} + {13'd0, x};
    return base + {6'd0, lin, 1'b0};
  endfunction

  assign src_x     = s_axis.tdata[15:0];
  assign src_y     = s_axis.tdata[31:16];
  assign in_range  = !src_x[15] && ($unsigned(src_x) < {4'd0, width_q}) &&
                     !src_y[15] && ($unsigned(src_y) < {4'd0, height_q});
  assign last_word = (col_q == width_q - 12'd1) && (row_q == height_q - 12'd1);

  always_comb begin
`ifdef RECT_ADDR_CLAMP_EN
    addr_nxt = pix_addr(base_q, width_q, clamp_coord(src_x, width_q),
                        clamp_coord(src_y, height_q));
`else
    addr_nxt = in_range ? pix_addr(base_q, width_q, src_x[11:0], src_y[11:0])
                        : FILL_ADDR;
`endif
  end

  // A new word may enter whenever the single output slot is empty or draining.
  assign s_axis.tready = (state_q == RUN) && (!vld_p0 || m_axis.tready);
  assign in_hs         = s_axis.tvalid && s_axis.tready;
  assign out_hs        = vld_p0 && m_axis.tready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (cfg_width == 12'd0 || cfg_height == 12'd0) ? DONE : RUN;
      RUN:  if (out_hs && tlast_p0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Frame configuration is held from the accepted start until the next one.
  always_ff @(posedge aclk) begin
    if (state_q == IDLE && start) begin
      base_q   <= cfg_base;
      width_q  <= cfg_width;
      height_q <= cfg_height;
    end
  end

  // Stage p0: output register loaded one cycle after the input handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_p0    <= 1'b0;
      tlast_p0  <= 1'b0;
      tdata_p0  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      frame_err <= 1'b0;
      oob_count <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        col_q     <= '0;
        row_q     <= '0;
        frame_err <= 1'b0;
        oob_count <= '0;
      end
      if (in_hs) begin
        vld_p0   <= 1'b1;
        tdata_p0 <= addr_nxt;
        tlast_p0 <= last_word;
        if (s_axis.tlast != last_word) frame_err <= 1'b1;
        if (!in_range) oob_count <= sat_inc(oob_count);
        if (col_q == width_q - 12'd1) begin
          col_q <= '0;
          row_q <= row_q + 12'd1;
        end else begin
          col_q <= col_q + 12'd1;
        end
      end else if (out_hs) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = vld_p0;
  assign m_axis.tdata  = tdata_p0;
  assign m_axis.tlast  = tlast_p0;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign state_out     = state_q;

endmodule

// File: tb/tb_rect_addr_gen.sv
// tb_rect_addr_gen -- directed frames against a coordinate-level model of the
// address generator, plus literal expectations for key addresses.
module tb_rect_addr_gen;
  localparam logic [31:0] FILL = 32'h40000000;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [11:0] cfg_width = '0, cfg_height = '0;
  logic        busy, done, frame_err;
  logic [15:0] oob_count;
  logic [1:0]  state_out;

  rect_addr_gen_if #(.W(32)) s_axis ();
  rect_addr_gen_if #(.W(32)) m_axis ();

  rect_addr_gen dut (
    .aclk(aclk), .areset(areset), .start(start),
    .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_axis(s_axis), .m_axis(m_axis),
    .busy(busy), .done(done), .frame_err(frame_err),
    .oob_count(oob_count), .state_out(state_out)
  );

  always #5 aclk = ~aclk;

  int checks = 0, errors = 0;

  // model state
  logic [31:0] m_base;
  int          m_w, m_h, idx, m_oob;
  logic [32:0] expq[$];
  logic [31:0] obs[16];
  int          out_cnt, done_cnt, mv_cnt;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [32:0] e;
  int          cx_in, cy_in;

  int wx[16], wy[16];
  bit wl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_oob(int x, int y);
    return (x < 0 || x >= m_w || y < 0 || y >= m_h);
  endfunction

  function automatic logic [31:0] model_addr(int x, int y);
    int cx, cy;
    cx = x; cy = y;
`ifdef RECT_ADDR_CLAMP_EN
    if (cx < 0) cx = 0;
    if (cx >= m_w) cx = m_w - 1;
    if (cy < 0) cy = 0;
    if (cy >= m_h) cy = m_h - 1;
    return m_base + 32'((cy * m_w + cx) * 2);
`else
    if (model_oob(x, y)) return FILL;
    return m_base + 32'((cy * m_w + cx) * 2);
`endif
  endfunction

  // Compare process: all sampling on the falling edge.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (m_axis.tvalid) mv_cnt++;
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_hold_valid", {31'b0, m_axis.tvalid}, 32'd1);
        chk("stall_hold_data", m_axis.tdata, prev_data);
      end
      if (m_axis.tvalid && !m_axis.tready)
        chk("stall_s_tready", {31'b0, s_axis.tready}, 32'd0);
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
      if (m_axis.tvalid && m_axis.tready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word: got %h expected none", m_axis.tdata);
        end else begin
          e = expq.pop_front();
          chk("addr", m_axis.tdata, e[31:0]);
          chk("tlast", {31'b0, m_axis.tlast}, {31'b0, e[32]});
        end
        if (out_cnt < 16) obs[out_cnt] = m_axis.tdata;
        out_cnt++;
      end
      if (s_axis.tvalid && s_axis.tready) begin
        cx_in = int'($signed(s_axis.tdata[15:0]));
        cy_in = int'($signed(s_axis.tdata[31:16]));
        expq.push_back({(idx == m_w * m_h - 1), model_addr(cx_in, cy_in)});
        if (model_oob(cx_in, cy_in)) m_oob++;
        idx++;
      end
    end
  end

  task automatic raster(input int w, input int h);
    for (int i = 0; i < 16; i++) begin
      wx[i] = (i < w * h) ? i % w : 0;
      wy[i] = (i < w * h) ? i / w : 0;
      wl[i] = (i == w * h - 1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic start_frame(input logic [31:0] base, input logic [11:0] w, input logic [11:0] h);
    m_base = base; m_w = int'(w); m_h = int'(h);
    idx = 0; m_oob = 0; expq.delete();
    out_cnt = 0; done_cnt = 0; mv_cnt = 0;
    cfg_base = base; cfg_width = w; cfg_height = h;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = {wy[i][15:0], wx[i][15:0]};
      s_axis.tlast  = wl[i];
      g = 0;
      @(negedge aclk);
      while (!s_axis.tready && g < 100) begin
        @(negedge aclk);
        g++;
      end
      if (!s_axis.tready) begin
        checks++; errors++;
        $display("FAIL s_tready_timeout: got 0 expected 1 at word %0d", i);
      end
      @(posedge aclk); #1;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic finish_frame(input int exp_oob, input int exp_ferr);
    int g;
    g = 0;
    @(negedge aclk);
    while (!done && g < 100) begin
      @(negedge aclk);
      g++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("state_done", {30'b0, state_out}, 32'd2);
    chk("oob_count", {16'b0, oob_count}, 32'(exp_oob));
    chk("oob_model", 32'(m_oob), 32'(exp_oob));
    chk("frame_err", {31'b0, frame_err}, 32'(exp_ferr));
    chk("queue_empty", 32'(expq.size()), 32'd0);
    @(negedge aclk);
    chk("done_low", {31'b0, done}, 32'd0);
    chk("state_idle", {30'b0, state_out}, 32'd0);
    chk("busy_low", {31'b0, busy}, 32'd0);
    chk("done_once", 32'(done_cnt), 32'd1);
    @(posedge aclk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, {30'b0, state_out}, 32'd0);
    chk({tag, "_mvalid"}, {31'b0, m_axis.tvalid}, 32'd0);
    chk({tag, "_sready"}, {31'b0, s_axis.tready}, 32'd0);
    chk({tag, "_tdata"}, m_axis.tdata, 32'd0);
    chk({tag, "_tlast"}, {31'b0, m_axis.tlast}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_ferr"}, {31'b0, frame_err}, 32'd0);
    chk({tag, "_oob"}, {16'b0, oob_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;

    // power-on reset
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check_reset_vals("rst");
    @(posedge aclk); #1;

    // basic 4x2 raster frame
    raster(4, 2);
    start_frame(32'h40000000, 12'd4, 12'd2);
    @(negedge aclk);
    chk("run_state", {30'b0, state_out}, 32'd1);
    chk("run_busy", {31'b0, busy}, 32'd1);
    @(posedge aclk); #1;
    send(8);
    finish_frame(0, 0);
    chk("basic_cnt", 32'(out_cnt), 32'd8);
    chk("basic_w0", obs[0], 32'h40000000);
    chk("basic_w1", obs[1], 32'h40000002);
    chk("basic_w5", obs[5], 32'h4000000A);
    chk("basic_w7", obs[7], 32'h4000000E);

    // out-of-range coordinates: (5,-1) and (2,2)
    raster(4, 2);
    wx[3] = 5; wy[3] = -1;
    wx[6] = 2; wy[6] = 2;
    start_frame(32'h40000000, 12'd4, 12'd2);
    send(8);
    finish_frame(2, 0);
`ifdef RECT_ADDR_CLAMP_EN
    chk("model_pin_oob", model_addr(5, -1), 32'h40000006);
    chk("oob_w3", obs[3], 32'h40000006);
    chk("oob_w6", obs[6], 32'h4000000C);
`else
    chk("model_pin_oob", model_addr(5, -1), FILL);
    chk("oob_w3", obs[3], FILL);
    chk("oob_w6", obs[6], FILL);
`endif
    chk("oob_w4", obs[4], 32'h40000008);

    // output stall mid-frame, address wrap-around, start ignored while running
    raster(4, 2);
    start_frame(32'hFFFFFFF8, 12'd4, 12'd2);
    cfg_base = 32'h12345678; cfg_width = 12'd1; cfg_height = 12'd1;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    fork
      send(8);
      begin
        int g;
        g = 0;
        while (out_cnt < 3 && g < 200) begin
          @(posedge aclk);
          g++;
        end
        #1 m_axis.tready = 1'b0;
        repeat (5) @(posedge aclk);
        #1 m_axis.tready = 1'b1;
      end
    join
    finish_frame(0, 0);
    chk("stall_cnt", 32'(out_cnt), 32'd8);
    chk("wrap_w0", obs[0], 32'hFFFFFFF8);
    chk("wrap_w4", obs[4], 32'h00000000);
    chk("wrap_w7", obs[7], 32'h00000006);

    // input tlast on word 3 of 8
    raster(4, 2);
    wl[2] = 1'b1;
    start_frame(32'h40000000, 12'd4, 12'd2);
    send(8);
    finish_frame(0, 1);
    chk("ferr_cnt", 32'(out_cnt), 32'd8);

    // reset after word 3, then a clean frame
    raster(4, 2);
    start_frame(32'h40000100, 12'd4, 12'd2);
    @(negedge aclk);
    chk("ferr_cleared", {31'b0, frame_err}, 32'd0);
    @(posedge aclk); #1;
    send(3);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    expq.delete();
    @(negedge aclk);
    check_reset_vals("midrst");
    chk("midrst_nodone", 32'(done_cnt), 32'd0);
    @(posedge aclk); #1;
    start_frame(32'h40000100, 12'd4, 12'd2);
    send(8);
    finish_frame(0, 0);
    chk("rerun_w0", obs[0], 32'h40000100);
    chk("rerun_w7", obs[7], 32'h4000010E);

    // zero-width frame
    start_frame(32'h40000000, 12'd0, 12'd2);
    @(negedge aclk);
    chk("zw_state", {30'b0, state_out}, 32'd2);
    chk("zw_done", {31'b0, done}, 32'd1);
    @(negedge aclk);
    chk("zw_done_low", {31'b0, done}, 32'd0);
    chk("zw_idle", {30'b0, state_out}, 32'd0);
    chk("zw_done_once", 32'(done_cnt), 32'd1);
    chk("zw_no_valid", 32'(mv_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rect_addr_gen.md
RECT_ADDR_GEN -- requirements
Module: rect_addr_gen

Interface
REQ-001 Param FILL_ADDR, 32'h40000000, address emitted for an out-of-range coordinate when clamping is compiled out.
REQ-002 Param C_AXIS_TDATA_WIDTH, 32, width of both streams.
REQ-003 aclk  in  1  single clock; all logic on posedge.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  frame start request, sampled in IDLE.
REQ-006 cfg_base  in  32  byte address of source pixel (0,0).
REQ-007 cfg_width, cfg_height  in  12 each  source image size in pixels.
REQ-008 s_axis_tvalid/s_axis_tready/s_axis_tlast  in/out/in  1 each  remap-map stream handshake.
REQ-009 s_axis_tdata  in  32  map word: [15:0] signed src x, [31:16] signed src y.
REQ-010 m_axis_tvalid/m_axis_tready/m_axis_tlast  out/in/out  1 each  address stream to the fetch stage.
REQ-011 m_axis_tdata  out  32  source pixel byte address.
REQ-012 busy, done, frame_err  out  1 each  status; oob_count out 16; state_out out 2.

Function
REQ-013 FSM states IDLE=0, RUN=1, DONE=2, reported on state_out.
REQ-014 IDLE: on start, latch cfg_base/width/height, clear col/row counters, frame_err, oob_count; go RUN, or go DONE if width or height is 0.
REQ-015 start outside IDLE is ignored; latched cfg does not change until the next accepted start.
REQ-016 s_axis_tready = RUN && (!m_axis_tvalid || m_axis_tready); 0 in IDLE and DONE.
REQ-017 Single output register: an input handshake loads m_axis_tdata/tlast and sets m_axis_tvalid on the next edge (1-cycle latency); m_axis_tvalid clears only on an output handshake with no simultaneous input handshake.
REQ-018 In-range: 0<=x<width and 0<=y<height; address = base + ((y*width + x) << 1), 24-bit unsigned product, 32-bit wrap-around sum.
REQ-019 Out-of-range coordinate: oob_count increments (saturates at 16'hFFFF); address per REQ-028/029.
REQ-020 col counts 0..width-1 per accepted word, then wraps to 0 and row increments; m_axis_tlast=1 only on word col=width-1, row=height-1.
REQ-021 If s_axis_tlast != computed last on any accepted word, frame_err sets (sticky until next start); no stream change.
REQ-022 After the tlast output handshake, go DONE; DONE lasts 1 cycle with done=1, then IDLE.
REQ-023 busy=1 in RUN and DONE, 0 in IDLE.

Reset
REQ-024 areset high at an edge: state IDLE, m_axis_tvalid 0, s_axis_tready 0, tdata 0, tlast 0, done 0, busy 0, frame_err 0, oob_count 0, counters 0.
REQ-025 Reset mid-frame discards the pending output word; no done pulse is produced.
REQ-026 Reset has priority over start and any handshake in the same cycle.

Configuration
REQ-027 Macro RECT_ADDR_CLAMP_EN selects out-of-range handling.
REQ-028 Defined: x clamped to [0,width-1] and y to [0,height-1], then REQ-018 applied.
REQ-029 Undefined: address = FILL_ADDR; oob_count behaviour unchanged.

Verification
REQ-030 base=32'h40000000, 4x2, map (0,0)..(3,1) raster, tready=1 -> addrs 40000000,02,04,06,08,0A,0C,0E; tlast on 8th only; done pulses once; oob_count=0.
REQ-031 4x2, map word (5,-1) with clamp on -> addr 40000006, oob_count=1; clamp off -> FILL_ADDR, oob_count=1.
REQ-032 m_axis_tready held 0 for 5 cycles mid-frame -> tdata/tvalid stable, s_axis_tready=0, no word lost or duplicated.
REQ-033 s_axis_tlast asserted on word 3 of 8 -> frame_err=1, stream continues, tlast still on word 8.
REQ-034 areset for 1 cycle after word 3 -> all outputs at reset values; new start runs a full frame from address base.
REQ-035 start with cfg_width=0 -> DONE next cycle, done=1 one cycle, no m_axis_tvalid.
